// File: rtl/text_console_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : text_console_ctrl_if
// Brief    : Key handshake, clear request, RAM write port and cursor status
//            shared between the console controller and its surroundings.
// Revision : 1.0 - initial release
// ============================================================================
interface text_console_ctrl_if;
  logic        key_valid;
  logic [7:0]  key_ascii;
  logic        key_ready;
  logic        clr;
  logic        busy;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;
  logic [4:0]  top_row;

  modport master (
    output key_valid, key_ascii, clr,
    input  key_ready, busy, wr_en, wr_addr, wr_data, cur_row, cur_col, top_row
  );

  modport slave (
    input  key_valid, key_ascii, clr,
    output key_ready, busy, wr_en, wr_addr, wr_data, cur_row, cur_col, top_row
  );
endinterface
`default_nettype wire

// File: rtl/text_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : text_console_ctrl
// Brief    : Character-buffer sequencer: cursor, wrap, newline, backspace,
//            circular-row scroll and buffer clears for a VGA text display.
// Revision : 1.0 - initial release
// ============================================================================
module text_console_ctrl #(
  parameter int         COLS  = 71,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input wire clk,
  input wire resetn,
  text_console_ctrl_if.slave bus
);

  localparam int CELLS = COLS * ROWS;

  typedef enum logic [1:0] {
    INIT_CLR = 2'd0,
    IDLE     = 2'd1,
    PUT      = 2'd2,
    LINE_CLR = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    K_NONE  = 2'd0,
    K_PRINT = 2'd1,
    K_NL    = 2'd2,
    K_BS    = 2'd3
  } kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [11:0] cnt_q, cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  top_q, top_d;
  logic        advance;
  logic        accept;

  // Logical row is rotated by the scroll base before forming the RAM address.
  function automatic logic [11:0] phys(input logic [4:0] trow,
                                       input logic [4:0] lrow,
                                       input logic [6:0] c);
    int p;
    p = int'(trow) + int'(lrow);
    if (p >= ROWS) p = p - ROWS;
    return 12'(p * COLS + int'(c));
  endfunction

  assign bus.key_ready = (state_q == IDLE) && !bus.clr;
  assign bus.busy      = (state_q != IDLE);
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.cur_row   = row_q;
  assign bus.cur_col   = col_q;
  assign bus.top_row   = top_q;

  assign accept = bus.key_valid && bus.key_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= INIT_CLR;
      kind_q    <= K_NONE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      top_q     <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      row_q     <= row_d;
      col_q     <= col_d;
      top_q     <= top_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    row_d     = row_q;
    col_d     = col_q;
    top_d     = top_q;
    advance   = 1'b0;

    case (state_q)
      INIT_CLR: begin
        row_d = '0;
        col_d = '0;
        top_d = '0;
        if (cnt_q < 12'(CELLS)) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = BLANK;
          cnt_d     = cnt_q + 12'd1;
        end else begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (bus.clr) begin
          // The first blank goes out on the sampling edge itself.
          state_d   = INIT_CLR;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = BLANK;
          cnt_d     = 12'd1;
          row_d     = '0;
          col_d     = '0;
          top_d     = '0;
        end else if (accept) begin
          state_d = PUT;
          kind_d  = K_NONE;
          if (bus.key_ascii >= 8'h20 && bus.key_ascii <= 8'h7E) begin
            kind_d    = K_PRINT;
            wr_en_d   = 1'b1;
            wr_addr_d = phys(top_q, row_q, col_q);
            wr_data_d = bus.key_ascii;
          end else if (bus.key_ascii == 8'h0D) begin
            kind_d = K_NL;
          end else if (bus.key_ascii == 8'h08) begin
            if (col_q != 7'd0) begin
              kind_d    = K_BS;
              wr_en_d   = 1'b1;
              wr_addr_d = phys(top_q, row_q, col_q - 7'd1);
              wr_data_d = BLANK;
            end else if (row_q != 5'd0) begin
              kind_d    = K_BS;
              wr_en_d   = 1'b1;
              wr_addr_d = phys(top_q, row_q - 5'd1, 7'(COLS - 1));
              wr_data_d = BLANK;
            end
          end
        end
      end

      PUT: begin
        state_d = IDLE;
        case (kind_q)
          K_PRINT: begin
            if (col_q == 7'(COLS - 1)) begin
              col_d   = '0;
              advance = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end
          K_NL: begin
            col_d   = '0;
            advance = 1'b1;
          end
          K_BS: begin
            if (col_q != 7'd0) begin
              col_d = col_q - 7'd1;
            end else begin
              row_d = row_q - 5'd1;
              col_d = 7'(COLS - 1);
            end
          end
          default: ;
        endcase

        if (advance) begin
          if (row_q < 5'(ROWS - 1)) begin
            row_d = row_q + 5'd1;
          end else begin
            // Old top physical row becomes the new bottom line; blank it.
            top_d     = (top_q == 5'(ROWS - 1)) ? 5'd0 : top_q + 5'd1;
            state_d   = LINE_CLR;
            wr_en_d   = 1'b1;
            wr_addr_d = phys(top_q, 5'd0, 7'd0);
            wr_data_d = BLANK;
            cnt_d     = 12'd1;
          end
        end
      end

      LINE_CLR: begin
        if (cnt_q < 12'(COLS)) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + 12'd1;
          wr_data_d = BLANK;
          cnt_d     = cnt_q + 12'd1;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = INIT_CLR;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_text_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_console_ctrl
// Brief    : Randomised self-checking bench against a logical-screen model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_console_ctrl;
  localparam int         COLS  = 71;
  localparam int         ROWS  = 30;
  localparam int         CELLS = COLS * ROWS;
  localparam int         BOUND = 5000;
  localparam logic [7:0] BLANK = 8'h20;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   cyc    = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   acc_cyc = 0;

  wr_t        wlog[$];
  logic [7:0] ram[CELLS];
  logic [7:0] mmem[CELLS];
  int         m_row, m_col, m_top;

  text_console_ctrl_if bus();

  text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench-side RAM and write log fed from the write port.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wlog.push_back('{int'(bus.wr_addr), int'(bus.wr_data), cyc});
      if (int'(bus.wr_addr) < CELLS) ram[int'(bus.wr_addr)] = bus.wr_data;
    end
  end

  // ---------------- reference model: logical screen over a rotating base
  function automatic int maddr(int r, int c);
    return ((m_top + r) % ROWS) * COLS + c;
  endfunction

  task automatic model_clear();
    foreach (mmem[i]) mmem[i] = BLANK;
    m_row = 0; m_col = 0; m_top = 0;
  endtask

  task automatic model_advance();
    if (m_row < ROWS - 1) m_row++;
    else begin
      for (int c = 0; c < COLS; c++) mmem[m_top * COLS + c] = BLANK;
      m_top = (m_top + 1) % ROWS;
    end
  endtask

  task automatic model_key(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      mmem[maddr(m_row, m_col)] = b;
      if (m_col == COLS - 1) begin m_col = 0; model_advance(); end
      else m_col++;
    end else if (b == 8'h0D) begin
      m_col = 0;
      model_advance();
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        mmem[maddr(m_row, m_col)] = BLANK;
      end else if (m_row > 0) begin
        m_row--;
        m_col = COLS - 1;
        mmem[maddr(m_row, m_col)] = BLANK;
      end
    end
  endtask

  // ---------------- drivers and log helpers
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(output int rdy_cyc);
    int n = 0;
    tick();
    while (bus.key_ready !== 1'b1 && n < BOUND) begin tick(); n++; end
    rdy_cyc = cyc;
    if (n >= BOUND) begin
      vectors++; miscompares++;
      $display("FAIL ready_timeout: key_ready=%b required 1", bus.key_ready);
    end
  endtask

  task automatic send_key(input logic [7:0] b);
    int n = 0;
    while (bus.key_ready !== 1'b1 && n < BOUND) begin tick(); n++; end
    if (n >= BOUND) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: key_ready=%b required 1", bus.key_ready);
    end
    bus.key_valid = 1'b1;
    bus.key_ascii = b;
    @(posedge clk);
    #1;
    acc_cyc       = cyc;
    bus.key_valid = 1'b0;
    bus.key_ascii = 8'($urandom);
    model_key(b);
  endtask

  task automatic clear_bad(output int bad);
    bad = 0;
    if (wlog.size() != CELLS) bad = 1;
    else
      for (int i = 0; i < CELLS; i++)
        if (wlog[i].addr != i || wlog[i].data != int'(BLANK) || wlog[i].cyc != wlog[0].cyc + i)
          bad++;
  endtask

  task automatic ram_bad(output int bad);
    bad = 0;
    for (int i = 0; i < CELLS; i++) if (ram[i] !== mmem[i]) bad++;
  endtask

  function automatic logic [39:0] snap();
    return {bus.wr_en, bus.wr_addr, bus.wr_data, bus.cur_row, bus.cur_col,
            bus.top_row, bus.key_ready, bus.busy};
  endfunction

  // ---------------- scenarios
  task automatic test_reset();
    int rdy, bad, rel;
    logic [39:0] exp;
    exp = {1'b0, 12'd0, 8'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b1};
    bus.key_valid = 1'b0; bus.clr = 1'b0; bus.key_ascii = 8'h00;
    resetn = 1'b0;
    repeat (3) tick();
    vectors++;
    if (snap() !== exp) begin miscompares++;
      $display("FAIL reset_values: got %h required %h", snap(), exp); end
    wlog.delete();
    model_clear();
    resetn = 1'b1;
    rel = cyc;
    wait_ready(rdy);
    clear_bad(bad);
    vectors++;
    if (bad != 0) begin miscompares++;
      $display("FAIL init_clear_seq: %0d bad of %0d writes, required 0 of %0d", bad, wlog.size(), CELLS); end
    vectors++;
    if (wlog.size() == 0 || wlog[0].cyc != rel + 1) begin miscompares++;
      $display("FAIL init_clear_start: first write cyc %0d required %0d", wlog.size() ? wlog[0].cyc : -1, rel + 1); end
    vectors++;
    if (wlog.size() == 0 || rdy != wlog[wlog.size()-1].cyc + 1) begin miscompares++;
      $display("FAIL init_ready_time: ready cyc %0d required last write + 1", rdy); end
    vectors++;
    if ({bus.busy, bus.cur_row, bus.cur_col, bus.top_row} !== 18'd0) begin miscompares++;
      $display("FAIL post_clear_state: busy %b row %0d col %0d top %0d required all 0",
               bus.busy, bus.cur_row, bus.cur_col, bus.top_row); end
  endtask

  task automatic test_basic();
    logic [7:0] chars [2];
    chars[0] = 8'h41; chars[1] = 8'h42;
    for (int k = 0; k < 2; k++) begin
      send_key(chars[k]);
      tick();
      vectors++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.key_ready} !== {1'b1, 12'(k), chars[k], 1'b0}) begin
        miscompares++;
        $display("FAIL basic_write_%0d: en %b addr %0d data %h ready %b required 1 %0d %h 0",
                 k, bus.wr_en, bus.wr_addr, bus.wr_data, bus.key_ready, k, chars[k]);
      end
      tick();
      vectors++;
      if ({bus.key_ready, bus.wr_en, bus.cur_col} !== {1'b1, 1'b0, 7'(k + 1)}) begin
        miscompares++;
        $display("FAIL basic_gap_%0d: ready %b en %b col %0d required 1 0 %0d",
                 k, bus.key_ready, bus.wr_en, bus.cur_col, k + 1);
      end
    end
  endtask

  task automatic test_wrap_scroll();
    int rdy, bad;
    for (int i = 0; i < COLS - 3; i++) send_key(8'($urandom_range(32, 126)));
    wait_ready(rdy);
    wlog.delete();
    send_key(8'h58);
    wait_ready(rdy);
    vectors++;
    if (wlog.size() != 1 || wlog[0].addr != COLS - 1 || wlog[0].data != 'h58) begin miscompares++;
      $display("FAIL wrap_write: %0d writes first addr %0d required 1 write 'X' at %0d",
               wlog.size(), wlog.size() ? wlog[0].addr : -1, COLS - 1); end
    vectors++;
    if (bus.cur_row !== 5'd1 || bus.cur_col !== 7'd0) begin miscompares++;
      $display("FAIL wrap_cursor: (%0d,%0d) required (1,0)", bus.cur_row, bus.cur_col); end
    for (int i = 0; i < ROWS - 2; i++) send_key(8'h0D);
    for (int i = 0; i < 5; i++) send_key(8'($urandom_range(32, 126)));
    wait_ready(rdy);
    vectors++;
    if (int'(bus.cur_row) != m_row || int'(bus.cur_col) != m_col) begin miscompares++;
      $display("FAIL bottom_cursor: (%0d,%0d) required (%0d,%0d)", bus.cur_row, bus.cur_col, m_row, m_col); end
    wlog.delete();
    send_key(8'h0D);
    wait_ready(rdy);
    bad = (wlog.size() != COLS) ? 1 : 0;
    if (bad == 0)
      for (int i = 0; i < COLS; i++)
        if (wlog[i].addr != i || wlog[i].data != int'(BLANK) || wlog[i].cyc != acc_cyc + 1 + i) bad++;
    vectors++;
    if (bad != 0) begin miscompares++;
      $display("FAIL scroll_clear: %0d bad, %0d writes required %0d blanks at 0..%0d", bad, wlog.size(), COLS, COLS - 1); end
    vectors++;
    if (rdy != acc_cyc + COLS + 1) begin miscompares++;
      $display("FAIL scroll_ready: ready cyc %0d required %0d", rdy, acc_cyc + COLS + 1); end
    vectors++;
    if ({bus.top_row, bus.cur_row, bus.cur_col} !== {5'd1, 5'(ROWS - 1), 7'd0}) begin miscompares++;
      $display("FAIL scroll_state: top %0d cursor (%0d,%0d) required 1 (%0d,0)",
               bus.top_row, bus.cur_row, bus.cur_col, ROWS - 1); end
    wlog.delete();
    send_key(8'h51);
    wait_ready(rdy);
    vectors++;
    if (wlog.size() != 1 || wlog[0].addr != 0 || wlog[0].data != 'h51) begin miscompares++;
      $display("FAIL post_scroll_write: addr %0d required 0 (Q)", wlog.size() ? wlog[0].addr : -1); end
    ram_bad(bad);
    vectors++;
    if (bad != 0) begin miscompares++;
      $display("FAIL scroll_ram: %0d cells differ, required 0", bad); end
  endtask

  task automatic test_random();
    int rdy, bad, r;
    logic [7:0] b;
    logic [7:0] junk [5];
    junk[0] = 8'h00; junk[1] = 8'h1B; junk[2] = 8'h7F; junk[3] = 8'h0A; junk[4] = 8'hFF;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 65)      b = 8'($urandom_range(32, 126));
      else if (r < 78) b = 8'h0D;
      else if (r < 95) b = 8'h08;
      else             b = junk[$urandom_range(0, 4)];
      send_key(b);
      wait_ready(rdy);
      vectors++;
      if (int'(bus.cur_row) != m_row || int'(bus.cur_col) != m_col || int'(bus.top_row) != m_top) begin
        miscompares++;
        $display("FAIL random_%0d key %h: (%0d,%0d) top %0d required (%0d,%0d) top %0d",
                 i, b, bus.cur_row, bus.cur_col, bus.top_row, m_row, m_col, m_top);
      end
    end
    ram_bad(bad);
    vectors++;
    if (bad != 0) begin miscompares++;
      $display("FAIL random_ram: %0d cells differ, required 0", bad); end
  endtask

  task automatic test_filter_clear();
    int rdy, bad, samp;
    wlog.delete();
    send_key(8'h1B);
    wait_ready(rdy);
    vectors++;
    if (wlog.size() != 0 || int'(bus.cur_row) != m_row || int'(bus.cur_col) != m_col) begin miscompares++;
      $display("FAIL filter_esc: %0d writes cursor (%0d,%0d) required 0 writes (%0d,%0d)",
               wlog.size(), bus.cur_row, bus.cur_col, m_row, m_col); end
    bus.clr = 1'b1; bus.key_valid = 1'b1; bus.key_ascii = 8'h41;
    #1;
    vectors++;
    if (bus.key_ready !== 1'b0) begin miscompares++;
      $display("FAIL clr_priority: key_ready %b required 0", bus.key_ready); end
    wlog.delete();
    @(posedge clk);
    #1;
    samp = cyc;
    bus.clr = 1'b0; bus.key_valid = 1'b0;
    model_clear();
    wait_ready(rdy);
    clear_bad(bad);
    vectors++;
    if (bad != 0) begin miscompares++;
      $display("FAIL clr_seq: %0d bad of %0d writes, required 0 of %0d", bad, wlog.size(), CELLS); end
    vectors++;
    if (wlog.size() == 0 || wlog[0].cyc != samp) begin miscompares++;
      $display("FAIL clr_start: first write cyc %0d required %0d", wlog.size() ? wlog[0].cyc : -1, samp); end
    vectors++;
    if ({bus.top_row, bus.cur_row, bus.cur_col, bus.busy} !== 18'd0) begin miscompares++;
      $display("FAIL clr_state: top %0d cursor (%0d,%0d) busy %b required 0 (0,0) 0",
               bus.top_row, bus.cur_row, bus.cur_col, bus.busy); end
  endtask

  task automatic test_backspace();
    int rdy, bad;
    for (int i = 0; i < COLS; i++) send_key(8'($urandom_range(32, 126)));
    wait_ready(rdy);
    wlog.delete();
    send_key(8'h08);
    tick();
    vectors++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 12'(COLS - 1), BLANK}) begin miscompares++;
      $display("FAIL bs_wrap_write: en %b addr %0d data %h required 1 %0d %h",
               bus.wr_en, bus.wr_addr, bus.wr_data, COLS - 1, BLANK); end
    wait_ready(rdy);
    vectors++;
    if (bus.cur_row !== 5'd0 || bus.cur_col !== 7'(COLS - 1)) begin miscompares++;
      $display("FAIL bs_wrap_cursor: (%0d,%0d) required (0,%0d)", bus.cur_row, bus.cur_col, COLS - 1); end
    for (int i = 0; i < COLS - 1; i++) send_key(8'h08);
    wait_ready(rdy);
    wlog.delete();
    send_key(8'h08);
    wait_ready(rdy);
    tick();
    vectors++;
    if (wlog.size() != 0 || bus.cur_row !== 5'd0 || bus.cur_col !== 7'd0) begin miscompares++;
      $display("FAIL bs_origin: %0d writes cursor (%0d,%0d) required 0 writes (0,0)",
               wlog.size(), bus.cur_row, bus.cur_col); end
    ram_bad(bad);
    vectors++;
    if (bad != 0) begin miscompares++;
      $display("FAIL bs_ram: %0d cells differ, required 0", bad); end
  endtask

  task automatic test_reset_mid_scroll();
    int rdy, bad, rel, n;
    logic [39:0] exp;
    exp = {1'b0, 12'd0, 8'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b1};
    for (int i = 0; i < ROWS - 1; i++) send_key(8'h0D);
    wait_ready(rdy);
    wlog.delete();
    send_key(8'h0D);
    n = 0;
    while (wlog.size() < 10 && n < 200) begin tick(); n++; end
    vectors++;
    if (wlog.size() < 10) begin miscompares++;
      $display("FAIL mid_scroll_reach: %0d writes required 10", wlog.size()); end
    resetn = 1'b0;
    #1;
    vectors++;
    if (snap() !== exp) begin miscompares++;
      $display("FAIL mid_scroll_reset: got %h required %h", snap(), exp); end
    repeat (2) tick();
    wlog.delete();
    model_clear();
    resetn = 1'b1;
    rel = cyc;
    wait_ready(rdy);
    clear_bad(bad);
    vectors++;
    if (bad != 0 || wlog.size() == 0 || wlog[0].cyc != rel + 1) begin miscompares++;
      $display("FAIL mid_scroll_reclear: %0d bad of %0d writes, required 0 of %0d", bad, wlog.size(), CELLS); end
    ram_bad(bad);
    vectors++;
    if (bad != 0) begin miscompares++;
      $display("FAIL final_ram: %0d cells differ, required 0", bad); end
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_ascii = 8'h00;
    bus.clr       = 1'b0;
    test_reset();
    test_basic();
    test_wrap_scroll();
    test_random();
    test_filter_clear();
    test_backspace();
    test_reset_mid_scroll();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/text_console_ctrl.md
# text_console_ctrl

Sequencing controller for the character buffer behind the VGA text display. It accepts ASCII bytes from the keyboard/lookup path through a valid/ready handshake and owns the write port of the character RAM. It maintains the cursor, line wrap, newline, backspace and hardware scroll via a circular row base, and clears the buffer after reset and on request. The display path reads the RAM independently and uses `top_row` to rotate rows.

## Interface
Parameters:
- `COLS`, default 71: characters per row (640 px / 9 px glyph).
- `ROWS`, default 30: rows on screen (480 px / 16 px glyph).
- `BLANK`, default 8'h20: fill byte used for all clears.

Ports:
- `clk` input 1: pixel/system clock; all state changes on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `key_valid` input 1: `key_ascii` holds a byte to consume.
- `key_ascii` input 8: ASCII code.
- `key_ready` output 1: controller can accept a byte this cycle.
- `clr` input 1: request a full clear (level; sampled only in IDLE).
- `busy` output 1: high in every state except IDLE.
- `wr_en` output 1: character RAM write strobe.
- `wr_addr` output 12: physical RAM address.
- `wr_data` output 8: byte to write.
- `cur_row` output 5: logical cursor row, 0..ROWS-1.
- `cur_col` output 7: cursor column, 0..COLS-1.
- `top_row` output 5: physical row shown at the top of the screen.

## Operation
- All outputs are registered. Reset values:
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `cur_row`=0, `cur_col`=0, `top_row`=0.
  - `key_ready`=0, `busy`=1.
  - state=INIT_CLR, clear counter=0.
- Physical address: `prow` = `top_row`+row, minus ROWS if the sum is ≥ROWS. Address = `prow`*COLS + col. Width is 12 bits (max 2129).
- States: INIT_CLR, IDLE, PUT, LINE_CLR.
- **INIT_CLR** (entered from reset or from IDLE when `clr`=1):
  - Writes BLANK to addresses 0..COLS*ROWS-1 in ascending order, one per cycle.
  - Cursor and `top_row` are forced to 0.
  - Goes to IDLE after the last write.
- **IDLE:**
  - `key_ready`=1 only here, and only when `clr`=0. `clr` has priority over `key_valid`.
  - A byte is accepted when `key_valid`&`key_ready` at a clock edge.
  - Classification:
    - 0x20..0x7E: printable.
    - 0x0D: newline.
    - 0x08: backspace.
    - Anything else: accepted and discarded, with no write and no cursor change.
- **PUT** (one cycle, then IDLE):
  - Printable:
    - Write the byte at the current cursor position.
    - `cur_col`+1. At `cur_col`=COLS-1, set `cur_col`=0 and perform a row advance.
  - Newline:
    - No write.
    - `cur_col`=0, then perform a row advance.
  - Backspace:
    - If `cur_col`>0: `cur_col`-1, then write BLANK at the new position.
    - Else if `cur_row`>0: `cur_row`-1 and `cur_col`=COLS-1, then write BLANK there.
    - Else (0,0): no write, no change.
- **Row advance:**
  - If `cur_row`<ROWS-1: `cur_row`+1.
  - Else: `cur_row` stays ROWS-1, `top_row` becomes (`top_row`+1) mod ROWS, and the FSM goes to LINE_CLR instead of IDLE.
- **LINE_CLR:**
  - Writes BLANK to the COLS addresses of the new bottom physical row (the old `top_row`), col 0..COLS-1 ascending.
  - Then goes to IDLE.

## Timing
- Acceptance edge E:
  - `wr_en`=1 with the address/data for the cycle E..E+1. The RAM captures it at E+1.
  - Cursor/`top_row` updates are visible after E+1.
  - `key_ready` is 0 during E..E+1 and returns to 1 after E+1 if no scroll occurs.
  - Sustained throughput is 1 byte per 2 cycles.
- Scroll:
  - `wr_en` is high for exactly COLS consecutive cycles starting at E+1.
  - `key_ready` returns one cycle after the last LINE_CLR write.
- Full clear:
  - `wr_en` is high for exactly COLS*ROWS (2130) consecutive cycles.
  - The first write is in the cycle after the first edge following reset release, or after `clr` is sampled in IDLE.
  - `key_ready` rises in the cycle after the last write.
- `wr_en` is 0 in every cycle not listed above. `wr_addr`/`wr_data` hold their last value when `wr_en`=0.
- Asserting `resetn` low mid-clear or mid-scroll immediately forces the reset values. A partial line is not resumed; a fresh full clear follows release.
- `key_valid` while `key_ready`=0 is ignored. The source must hold it.
- `clr` asserted in a non-IDLE state is ignored until IDLE.

## Test plan
- **Reset clear.** Release reset → `wr_en` is high for 2130 cycles with addresses 0..2129 and data 0x20, then `key_ready`=1, `busy`=0, cursor (0,0).
- **Basic write.** Send 'A' (0x41), then 'B' → writes 0x41@0 and 0x42@1. `cur_col`=2. Each `key_ready` gap is 1 cycle.
- **Wrap and scroll.**
  - Type 70 chars, then 'X' at col 70: the write lands at addr 70, and the cursor moves to (1,0).
  - From (29,x), send 0x0D: `top_row`=1, then 71 BLANK writes to addrs 0..70.
  - The next 'Q' writes to addr 0 (physical row 0 = logical row 29).
- **Backspace.**
  - At (1,0), send 0x08: cursor (0,70), writes 0x20@70.
  - At (0,0), send 0x08: no `wr_en`, cursor unchanged.
- **Filtering and clear.**
  - Send 0x1B: accepted, no write, cursor unchanged.
  - Assert `clr` together with `key_valid` in IDLE: the key is not accepted, a 2130-cycle clear runs, and `top_row`=0 and the cursor is (0,0) afterward.
- **Reset mid-scroll.** Pull `resetn` low at LINE_CLR write 10 → outputs are at reset values immediately. After release, a full 2130-write clear runs.
